sad_acc_min: RTL
================

SAD_ACC_MIN -- requirements
Module: sad_acc_min

Interface
REQ-001 Parameter PIXEL, default 8: bit width of each absolute-difference value.
REQ-002 Parameter NUM_PE, default 8: number of PE abs outputs summed per row.
REQ-003 Parameter ROWS, default 8: number of rows making up one candidate block SAD.
REQ-004 Parameter NUM_CAND, default 64: number of candidates per search; index width is log2(NUM_CAND) (6 bits at default).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse that begins a new search.
REQ-009 abs_in  input  NUM_PE*PIXEL  packed PE abs outputs; PE k occupies bits [k*PIXEL +: PIXEL].
REQ-010 abs_valid  input  1  abs_in holds one valid row.
REQ-011 busy  output  1  high while the search is running.
REQ-012 sad_out  output  14  SAD of the most recently completed candidate.
REQ-013 sad_valid  output  1  one-cycle pulse; sad_out has just been updated.
REQ-014 best_sad  output  14  minimum SAD so far in the current search.
REQ-015 best_idx  output  6  candidate index that produced best_sad.
REQ-016 done  output  1  one-cycle pulse; the search has completed.

Function
REQ-017 FSM states SHALL be: IDLE and ACCUM.
- IDLE to ACCUM on start.
- ACCUM to IDLE at the edge that completes candidate NUM_CAND-1.
- start received in ACCUM SHALL restart the search from ACCUM.
REQ-018 busy SHALL be 1 exactly when the state is ACCUM.
REQ-019 Row stage: at each edge with state ACCUM and abs_valid=1:
- row_sum_q <= sum of the NUM_PE values, 11 bits unsigned, no truncation (maximum 2040).
- row_v_q <= 1; otherwise row_v_q <= 0.
REQ-020 abs_valid SHALL be ignored in IDLE and in the cycle start is high.
REQ-021 Accumulate stage: at each edge with row_v_q=1:
- acc <= row_sum_q when row_cnt=0, else acc + row_sum_q; acc is 14 bits (maximum 16320, no overflow).
- row_cnt increments, wrapping from ROWS-1 to 0.
REQ-022 Candidate completion occurs at the edge with row_v_q=1 and row_cnt=ROWS-1:
- sad_out <= acc + row_sum_q.
- sad_valid is high for the following cycle only.
- cand_cnt increments.
REQ-023 Latency: sad_valid SHALL be high in the cycle beginning two edges after the edge that samples the last row's abs_valid.
REQ-024 Best update at the same completion edge:
- If the completed SAD < best_sad, or the candidate is cand_cnt=0: best_sad <= SAD and best_idx <= cand_cnt.
- On a tie the earlier index is kept.
REQ-025 Completion of candidate NUM_CAND-1 SHALL pulse done for one cycle, coincident with sad_valid, and return the FSM to IDLE.
REQ-026 best_sad, best_idx and sad_out SHALL hold their values in IDLE until the next start.
REQ-027 start SHALL synchronously clear row_cnt, cand_cnt, acc and row_v_q, set best_sad to 14'h3FFF and best_idx to 0, and discard any partial candidate.
REQ-028 Gaps in abs_valid SHALL stall accumulation without loss; rows need not be contiguous.
REQ-029 A row already in row_v_q when the FSM leaves ACCUM SHALL NOT occur by construction; any surplus abs_valid after the last candidate SHALL be ignored.

Reset
REQ-030 While rst_n=0, all of the following SHALL hold asynchronously: state IDLE, busy=0, sad_valid=0, done=0, sad_out=0, best_sad=14'h3FFF, best_idx=0, acc=0, row_sum_q=0, row_v_q=0, row_cnt=0, cand_cnt=0.
REQ-031 Reset asserted mid-search SHALL abort the search, and no done SHALL follow.
REQ-032 The first start after reset release SHALL behave identically to a start from IDLE.

Verification
REQ-033 Fill scenario: start, then 8 rows with every abs=255 for each of 64 candidates -> every sad_out=16320, best_sad=16320, best_idx=0, one done pulse coincident with the 64th sad_valid.
REQ-034 Minimum scenario: candidate 37 uses abs=1 and all other candidates use abs=10 -> best_sad=64, best_idx=37; all other sad_out=640.
REQ-035 Tie scenario: candidates 5 and 20 both give SAD 100 and all others give SAD 200 -> best_idx=5, best_sad=100.
REQ-036 Gap scenario: rows separated by random idle cycles -> sad_out equals the reference sum, and sad_valid occurs exactly 2 edges after the sampling of the 8th row.
REQ-037 Restart scenario: start pulsed after 3 rows of candidate 10 -> cand_cnt=0 and best_sad=14'h3FFF; the next 8 rows form candidate 0.
REQ-038 Reset scenario: rst_n low mid-search -> all outputs take their REQ-030 values immediately, with no done, and abs_valid is ignored until start.

Source files
------------

// File: rtl/sad_acc_min.sv
// Row-sum / block-accumulate SAD engine for motion search.
// Tracks the minimum candidate SAD and its index across one search.
module sad_acc_min #(
   parameter int PIXEL    = 8,
   parameter int NUM_PE   = 8,
   parameter int ROWS     = 8,
   parameter int NUM_CAND = 64,
   localparam int RSW = PIXEL + $clog2(NUM_PE),
   localparam int SW  = RSW + $clog2(ROWS),
   localparam int IW  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [NUM_PE*PIXEL-1:0] abs_in,
   input  logic                    abs_valid,
   output logic                    busy,
   output logic [SW-1:0]           sad_out,
   output logic                    sad_valid,
   output logic [SW-1:0]           best_sad,
   output logic [IW-1:0]           best_idx,
   output logic                    done
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t         state;
   state_t         state_nx;
   logic [RSW-1:0] row_sum;
   logic [RSW-1:0] row_sum_q;
   logic           row_v_q;
   logic [SW-1:0]  acc;
   logic [SW-1:0]  sad;
   logic [RW-1:0]  row_cnt;
   logic [IW-1:0]  cand_cnt;
   logic           complete;
   logic           last;

   always_comb begin
      row_sum = '0;
      for (int k = 0; k < NUM_PE; k++)
         row_sum = row_sum + RSW'(abs_in[k*PIXEL +: PIXEL]);
   end

   assign busy     = (state == ACCUM);
   assign complete = busy && row_v_q && (row_cnt == RW'(ROWS-1));
   assign last     = complete && (cand_cnt == IW'(NUM_CAND-1));
   assign sad      = ((row_cnt == '0) ? '0 : acc) + SW'(row_sum_q);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = ACCUM;
         ACCUM: begin
            if (start)     state_nx = ACCUM;
            else if (last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_sum_q <= '0;
         row_v_q   <= 1'b0;
         acc       <= '0;
         row_cnt   <= '0;
         cand_cnt  <= '0;
         sad_out   <= '0;
         sad_valid <= 1'b0;
         done      <= 1'b0;
         best_sad  <= '1;
         best_idx  <= '0;
      end else if (start) begin
         row_v_q   <= 1'b0;
         acc       <= '0;
         row_cnt   <= '0;
         cand_cnt  <= '0;
         sad_valid <= 1'b0;
         done      <= 1'b0;
         best_sad  <= '1;
         best_idx  <= '0;
      end else begin
         // rows arriving on the final completion edge are surplus
         row_v_q   <= busy && abs_valid && !last;
         sad_valid <= complete;
         done      <= last;
         if (busy && abs_valid)
            row_sum_q <= row_sum;
         if (busy && row_v_q) begin
            acc     <= sad;
            row_cnt <= complete ? '0 : row_cnt + RW'(1);
            if (complete) begin
               sad_out  <= sad;
               cand_cnt <= cand_cnt + IW'(1);
               if (sad < best_sad || cand_cnt == '0) begin
                  best_sad <= sad;
                  best_idx <= cand_cnt;
               end
            end
         end
      end
   end

endmodule
